// File: rtl/tile_ram_clr.sv
// Tile memory for the snake playfield.
// Port A is read/write for game logic. Port B is a read-only video port.
// A built-in sequencer rewrites the whole array as background plus the
// initial snake segment.
// Array contents survive i_rst. Only the control state and the output
// registers are reset.
module tile_ram_clr #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 3,
  parameter int unsigned DEPTH       = 2400,
  parameter int unsigned CLEAR_VALUE = 0,
  parameter int unsigned FILL_LO     = 2020,
  parameter int unsigned FILL_HI     = 2040,
  parameter int unsigned FILL_VALUE  = 4,
  parameter bit          AUTO_CLEAR  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_a_addr,
  input  logic                  i_a_write,
  input  logic [DATA_WIDTH-1:0] i_a_data,
  output logic [DATA_WIDTH-1:0] o_a_data,
  input  logic [ADDR_WIDTH-1:0] i_b_addr,
  output logic [DATA_WIDTH-1:0] o_b_data,
  input  logic                  i_clear,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

  localparam state_e                  ResetState = AUTO_CLEAR ? StClear : StIdle;
  localparam logic [DATA_WIDTH-1:0]   ClearWord  = DATA_WIDTH'(CLEAR_VALUE);
  localparam logic [DATA_WIDTH-1:0]   FillWord   = DATA_WIDTH'(FILL_VALUE);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic                  sweep;
  logic                  cnt_last;
  logic                  in_fill;
  logic                  a_in_range;
  logic                  b_in_range;
  logic                  a_rd_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Address decodes. cnt never exceeds DEPTH-1, so the fill window is clipped
  // implicitly, and FILL_LO > FILL_HI can never match.
  always_comb begin
    sweep      = (state_q == StClear);
    cnt_last   = (32'(cnt_q) == DEPTH - 1);
    in_fill    = (32'(cnt_q) >= FILL_LO) && (32'(cnt_q) <= FILL_HI);
    a_in_range = (32'(i_a_addr) < DEPTH);
    b_in_range = (32'(i_b_addr) < DEPTH);
  end

  // Sequencer next-state and sweep counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (i_clear) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_last) begin
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sequencer state register; reset aborts any sweep in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ResetState;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write-port arbitration. The sweep owns the write port and drops port A.
  // Writes are held off while reset is asserted, so the array is left intact.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = i_a_addr;
    mem_wdata = i_a_data;
    a_rd_en   = 1'b0;
    if (sweep) begin
      mem_we    = !i_rst;
      mem_waddr = cnt_q;
      mem_wdata = in_fill ? FillWord : ClearWord;
    end else begin
      mem_we  = !i_rst && i_a_write && a_in_range;
      a_rd_en = !i_a_write;
    end
  end

  // Status flags are decodes of the registered state, so they cannot glitch.
  always_comb begin
    o_busy = (state_q == StClear);
    o_done = (state_q == StDone);
  end

  // Array write; no reset on storage.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Port A read register. It holds during its own writes and during a sweep.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_a_data <= '0;
    end else if (a_rd_en) begin
      o_a_data <= a_in_range ? mem[i_a_addr] : '0;
    end
  end

  // Port B read register. It reads first, so a write on the same edge is not seen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_b_data <= '0;
    end else begin
      o_b_data <= b_in_range ? mem[i_b_addr] : '0;
    end
  end

endmodule

// File: tb/tb_tile_ram_clr.sv
// Directed bench for tile_ram_clr.
// Instance u_dut uses the default parameters and AUTO_CLEAR=1.
// Instance u_dut0 uses AUTO_CLEAR=0 and exercises abort by reset in mid-sweep.
module tb_tile_ram_clr;

  logic        clk;
  logic        rst, a_write, clr;
  logic [11:0] a_addr, b_addr;
  logic [2:0]  a_data, a_q, b_q;
  logic        busy, done;

  logic        rst0, a_write0, clr0;
  logic [11:0] a_addr0, b_addr0;
  logic [2:0]  a_data0, a_q0, b_q0;
  logic        busy0, done0;

  int checks   = 0;
  int failures = 0;
  int n, gaps, cnt;

  tile_ram_clr u_dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_a_addr (a_addr),
    .i_a_write(a_write),
    .i_a_data (a_data),
    .o_a_data (a_q),
    .i_b_addr (b_addr),
    .o_b_data (b_q),
    .i_clear  (clr),
    .o_busy   (busy),
    .o_done   (done)
  );

  tile_ram_clr #(.AUTO_CLEAR(1'b0)) u_dut0 (
    .i_clk    (clk),
    .i_rst    (rst0),
    .i_a_addr (a_addr0),
    .i_a_write(a_write0),
    .i_a_data (a_data0),
    .o_a_data (a_q0),
    .i_b_addr (b_addr0),
    .o_b_data (b_q0),
    .i_clear  (clr0),
    .o_busy   (busy0),
    .o_done   (done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Counts edges until o_done rises (bounded); gaps counts samples with neither flag.
  task automatic wait_done(output int edges, output int idle_gaps);
    edges     = 0;
    idle_gaps = 0;
    do begin
      tick();
      edges++;
      if (!done && !busy) idle_gaps++;
    end while (!done && edges < 5000);
  endtask

  function automatic logic [2:0] exp_tile(input int addr);
    return (addr >= 2020 && addr <= 2040) ? 3'd4 : 3'd0;
  endfunction

  int pre1 [7] = '{0, 1000, 2019, 2020, 2040, 2041, 2399};
  int pre0 [6] = '{0, 500, 999, 1000, 1001, 2399};
  logic [2:0] exp0 [6] = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7};

  initial begin
    rst = 1'b1;  a_write = 1'b0;  clr = 1'b0;  a_addr = '0;  b_addr = '0;  a_data = '0;
    rst0 = 1'b1; a_write0 = 1'b0; clr0 = 1'b0; a_addr0 = '0; b_addr0 = '0; a_data0 = '0;
    #1;
    chk("rst_busy",  busy,  1);
    chk("rst_done",  done,  0);
    chk("rst_a_q",   a_q,   0);
    chk("rst_b_q",   b_q,   0);
    chk("rst0_busy", busy0, 0);
    chk("rst0_done", done0, 0);
    tick();
    tick();
    rst  = 1'b0;
    rst0 = 1'b0;

    // Auto sweep after reset release
    wait_done(n, gaps);
    chk("auto_len",  n,    2400);
    chk("auto_gaps", gaps, 0);
    tick();
    chk("auto_done_low", done, 0);
    chk("auto_idle",     busy, 0);

    // Preload with 7 then re-sweep via reset pulse
    foreach (pre1[i]) begin
      a_addr = 12'(pre1[i]); a_write = 1'b1; a_data = 3'd7;
      tick();
    end
    a_write = 1'b0;
    a_addr  = 12'd2020;
    tick();
    chk("preload_rd", a_q, 7);
    rst = 1'b1;
    #1;
    chk("rst2_busy", busy, 1);
    chk("rst2_done", done, 0);
    chk("rst2_a_q",  a_q,  0);
    tick();
    rst = 1'b0;
    wait_done(n, gaps);
    chk("sweep_len",  n,    2400);
    chk("sweep_gaps", gaps, 0);
    cnt = 0;
    for (int i = 0; i < 2400; i++) begin
      b_addr = 12'(i);
      tick();
      if (done) cnt++;
      chk($sformatf("scan_%0d", i), b_q, exp_tile(i));
    end
    chk("single_done", cnt, 0);

    // Port A write then read; output holds during write
    a_addr = 12'd100; a_write = 1'b1; a_data = 3'd5;
    tick();
    chk("a_hold_on_write", a_q, 4);
    a_write = 1'b0;
    tick();
    chk("a_read_back", a_q, 5);

    // Same-edge write on A and read on B returns the old value
    a_addr = 12'd50; a_write = 1'b1; a_data = 3'd3; b_addr = 12'd50;
    tick();
    chk("b_read_first", b_q, 0);
    a_write = 1'b0;
    tick();
    chk("b_read_new", b_q, 3);
    chk("a_read_50",  a_q, 3);

    // Port A write dropped during sweep; second clear ignored
    clr = 1'b1;
    tick();
    chk("clr_busy", busy, 1);
    clr = 1'b0;
    a_addr = 12'd10; a_write = 1'b1; a_data = 3'd6;
    tick();
    chk("a_hold_clear", a_q, 3);
    a_write = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_done(n, gaps);
    chk("clr_len", n, 2398);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done || busy) cnt++;
    end
    chk("no_requeue", cnt, 0);
    a_addr = 12'd10;
    tick();
    chk("dropped_write", a_q, 0);
    a_addr = 12'd100;
    tick();
    chk("swept_100", a_q, 0);
    a_addr = 12'd2030;
    tick();
    chk("fill_2030", a_q, 4);

    // Out-of-range addresses
    a_addr = 12'd2400;
    tick();
    chk("a_oob_rd", a_q, 0);
    b_addr = 12'd2030;
    tick();
    chk("b_2030", b_q, 4);
    b_addr = 12'd2400;
    tick();
    chk("b_oob_rd", b_q, 0);
    a_addr = 12'd2500; a_write = 1'b1; a_data = 3'd7;
    tick();
    a_write = 1'b0;
    a_addr = 12'd100;
    tick();
    chk("oob_alias_100", a_q, 0);
    a_addr = 12'd452;
    tick();
    chk("oob_alias_452", a_q, 0);
    b_addr = 12'd2399;
    tick();
    chk("oob_alias_2399", b_q, 0);

    // i_clear held high: back-to-back sweeps with one DONE and one IDLE cycle
    clr = 1'b1;
    tick();
    chk("held_busy", busy, 1);
    wait_done(n, gaps);
    chk("held_len1", n, 2400);
    tick();
    chk("held_gap_busy", busy, 0);
    chk("held_gap_done", done, 0);
    tick();
    chk("held_retrig", busy, 1);
    clr = 1'b0;
    wait_done(n, gaps);
    chk("held_len2", n, 2400);
    tick();
    chk("held_end", busy, 0);

    // AUTO_CLEAR=0: abort by reset after 1000 sweep writes
    foreach (pre0[i]) begin
      a_addr0 = 12'(pre0[i]); a_write0 = 1'b1; a_data0 = 3'd7;
      tick();
    end
    a_write0 = 1'b0;
    clr0 = 1'b1;
    tick();
    chk("c0_busy", busy0, 1);
    clr0 = 1'b0;
    repeat (1000) tick();
    rst0 = 1'b1;
    #1;
    chk("c0_abort_busy", busy0, 0);
    chk("c0_abort_done", done0, 0);
    tick();
    rst0 = 1'b0;
    tick();
    tick();
    chk("c0_stays_idle", busy0, 0);
    foreach (pre0[i]) begin
      b_addr0 = 12'(pre0[i]);
      tick();
      chk($sformatf("c0_mem_%0d", pre0[i]), b_q0, exp0[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
